kbd_scancode_ctrl: RTL
======================

Name: kbd_scancode_ctrl

Overview:
Sequences the PS/2 byte receiver's output stream into key events. It consumes received bytes and their one-cycle new-byte strobe, and decodes set-2 scan-code prefixes (E0 extended, F0 break, E1 pause). Decoded make/break events go into a small first-word-fall-through (FWFT) event FIFO for the game logic. It also keeps held-key levels for the keys the game uses.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2.
TIMEOUT_CYCLES, 1000000, max clk cycles between bytes of one multi-byte sequence (20 ms @ 50 MHz).

Ports:
clk  in  1  system clock
resetN  in  1  reset
din  in  8  received byte, valid when din_new=1
din_new  in  1  one-cycle strobe, new byte on din
event_pop  in  1  consume head event; ignored when event_valid=0
clear_err  in  1  clears overflow_err
event_valid  out  1  FIFO not empty
event_code  out  8  head scan code (last byte of sequence)
event_ext  out  1  head event had E0 prefix
event_make  out  1  head: 1=make, 0=break
overflow_err  out  1  sticky: an event was dropped on full FIFO
timeout_pulse  out  1  one cycle: partial sequence abandoned
key_left, key_right, key_up, key_down, key_space, key_enter, key_esc  out  1 each  held-key levels

Behaviour:
- Reset: resetN asynchronous, active-low; clock clk. All outputs 0, FIFO empty, FSM in IDLE_ST, timeout counter 0.
- FSM states: IDLE_ST, EXT_ST (E0 seen), BRK_ST (F0 seen), EXT_BRK_ST (E0 F0 seen), PAUSE_ST (E1 seen; skip count held).
- All transitions happen only on cycles with din_new=1, except timeout.
- IDLE_ST:
  - E0 -> EXT_ST.
  - F0 -> BRK_ST.
  - E1 -> PAUSE_ST with skip=7.
  - FA, AA, EE, FE, 00, FF -> ignored, stay.
  - Any other byte -> push make event {ext=0, code=din}.
- EXT_ST:
  - F0 -> EXT_BRK_ST.
  - E0 -> stay in EXT_ST.
  - 12 or 59 (fake shift) -> IDLE_ST, no event.
  - Other -> push make {ext=1}, then IDLE_ST.
- BRK_ST: any byte -> push break {ext=0, code=din}, then IDLE_ST.
- EXT_BRK_ST:
  - 12 or 59 -> IDLE_ST, no event.
  - Other -> push break {ext=1}, then IDLE_ST.
- PAUSE_ST: each byte decrements skip. When a byte arrives with skip=1 -> push make {ext=1, code=E1}, then IDLE_ST. No break event is ever issued for pause.
- Timeout:
  - Counter clears on every din_new and while in IDLE_ST; otherwise it increments.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE_ST, timeout_pulse=1 for that one cycle, no event.
  - din_new in the timeout cycle wins: the byte is processed and no timeout fires.
- Latency: the push and key-level update occur on the same clk edge that samples din_new=1. event_valid and the key levels are visible the next cycle.
- Key levels: set on make, cleared on break, for:
  - ext=1: 6B left, 74 right, 75 up, 72 down.
  - ext=0: 29 space, 5A enter, 76 esc.
  - Levels update even when the FIFO push is dropped.
- FIFO (FWFT):
  - event_code/ext/make show the head entry while event_valid=1; they are 0 when empty.
  - Pop and push in the same cycle: both succeed, including when full. Count is unchanged.
  - Push when full without pop: the event is dropped and overflow_err is set.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow_err: clear_err clears it. A simultaneous set (drop) and clear_err leaves it set.
- Event order in the FIFO matches byte arrival order.
- Reset mid-sequence: FSM, FIFO, levels and counters return to reset values immediately.

Test Plan:
1. Bytes 29, then F0 29 -> events {29, ext0, make1} then {29, ext0, make0}; key_space high between the two; FIFO holds 2 entries until popped.
2. E0 6B, then E0 F0 6B, then E0 12 -> key_left 1 then 0; exactly two events with ext=1; fake-shift E0 12 produces none.
3. E0, then no byte for TIMEOUT_CYCLES (set to 16 for sim) -> timeout_pulse exactly one cycle at count 15, FSM back in IDLE_ST; next byte 1C gives make {1C, ext0}.
4. With FIFO_DEPTH=4 and no pops, send 5 make codes 15,1D,24,2D,2C -> event_valid=1, overflow_err=1, and pops return 15,1D,24,2D. Push with pop while full -> no drop. Raise clear_err -> overflow_err=0.
5. Pause sequence E1 14 77 E1 F0 14 F0 77 -> single event {E1, ext1, make1}, no break event, all key levels unchanged.
6. Send FA and AA -> no events. Assert resetN=0 during BRK_ST with 2 events queued -> all outputs 0; after release, F0 29 decodes correctly.

Source files
------------

// File: rtl/kbd_scancode_ctrl.sv
// kbd_scancode_ctrl: decodes PS/2 set-2 scan-code bytes into make/break events
// held in a first-word-fall-through FIFO, and tracks held-key levels for the game.
module kbd_scancode_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] din,
    input  logic       din_new,
    input  logic       event_pop,
    input  logic       clear_err,
    output logic       event_valid,
    output logic [7:0] event_code,
    output logic       event_ext,
    output logic       event_make,
    output logic       overflow_err,
    output logic       timeout_pulse,
    output logic       key_left,
    output logic       key_right,
    output logic       key_up,
    output logic       key_down,
    output logic       key_space,
    output logic       key_enter,
    output logic       key_esc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE_ST, EXT_ST, BRK_ST, EXT_BRK_ST, PAUSE_ST} state_t;

    state_t        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rptr_q, wptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic [6:0]    keys_q, keys_d, key_hit;
    logic [7:0]    ev_code;
    logic          ev_push, ev_ext, ev_make, fake_shift, ignored, full, pop, push, drop;

    assign fake_shift = din == 8'h12 || din == 8'h59;
    assign ignored    = din inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    assign ev_code    = state_q == PAUSE_ST ? 8'hE1 : din;

    always_comb begin
        state_d       = state_q;
        skip_d        = skip_q;
        ev_push       = 1'b0;
        ev_ext        = 1'b0;
        ev_make       = 1'b1;
        timeout_pulse = 1'b0;
        if (din_new) begin
            case (state_q)
                IDLE_ST: begin
                    state_d = din == 8'hE0 ? EXT_ST : din == 8'hF0 ? BRK_ST :
                              din == 8'hE1 ? PAUSE_ST : IDLE_ST;
                    skip_d  = 3'd7;
                    ev_push = state_d == IDLE_ST && !ignored;
                end
                EXT_ST: begin
                    state_d = din == 8'hF0 ? EXT_BRK_ST : din == 8'hE0 ? EXT_ST : IDLE_ST;
                    ev_push = state_d == IDLE_ST && !fake_shift;
                    ev_ext  = 1'b1;
                end
                BRK_ST: begin
                    state_d = IDLE_ST;
                    ev_push = 1'b1;
                    ev_make = 1'b0;
                end
                EXT_BRK_ST: begin
                    state_d = IDLE_ST;
                    ev_push = !fake_shift;
                    ev_ext  = 1'b1;
                    ev_make = 1'b0;
                end
                PAUSE_ST: begin
                    skip_d  = skip_q - 1'b1;
                    ev_push = skip_q == 3'd1;
                    ev_ext  = 1'b1;
                    state_d = skip_q == 3'd1 ? IDLE_ST : PAUSE_ST;
                end
                default: state_d = IDLE_ST;
            endcase
        end else if (state_q != IDLE_ST && cnt_q == CNT_LAST) begin
            state_d       = IDLE_ST;
            timeout_pulse = 1'b1;
        end
    end

    assign cnt_d = (din_new || state_q == IDLE_ST || timeout_pulse) ? '0 : cnt_q + 1'b1;

    // Key bits: {esc, enter, space, down, up, right, left}
    assign key_hit = {!ev_ext && ev_code == 8'h76, !ev_ext && ev_code == 8'h5A,
                      !ev_ext && ev_code == 8'h29, ev_ext && ev_code == 8'h72,
                      ev_ext && ev_code == 8'h75, ev_ext && ev_code == 8'h74,
                      ev_ext && ev_code == 8'h6B};
    assign keys_d  = !ev_push ? keys_q : ev_make ? keys_q | key_hit : keys_q & ~key_hit;

    assign full        = count_q == (AW+1)'(FIFO_DEPTH);
    assign event_valid = count_q != '0;
    assign pop         = event_pop && event_valid;
    assign push        = ev_push && (!full || pop);
    assign drop        = ev_push && full && !pop;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE_ST;
            skip_q  <= '0;
            cnt_q   <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            keys_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            rptr_q  <= rptr_q + AW'(pop);
            wptr_q  <= wptr_q + AW'(push);
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            ovf_q   <= drop | (ovf_q & ~clear_err);
            keys_q  <= keys_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {ev_ext, ev_make, ev_code};
    end

    assign {event_ext, event_make, event_code} = event_valid ? mem_q[rptr_q] : '0;
    assign overflow_err = ovf_q;
    assign {key_esc, key_enter, key_space, key_down, key_up, key_right, key_left} = keys_q;
endmodule
